// File: rtl/life_display_scanner.sv
// life_display_scanner
// Reads the life board back out of the board RAM, one row at a time, and
// serialises each row onto a shift-register LED display (data/clock/latch).
// It shares the RAM with the life controller through a busy handshake and
// raises `next_o` every FRAMES_PER_GEN displayed frames to advance the board.
//
// Optional feature (macro LIFE_SCAN_CENSUS_EN): adds population_o, the number
// of live cells in the most recently completed frame.
//
// Ports:
//   clk_50MHz_i     system clock
//   rst_async_ha_i  asynchronous, active-high reset
//   enable_i        1 = scanning allowed, 0 = stop after the current row
//   row_from_ram_i  RAM read data, valid one clock after ram_addr_o
//   ctrl_busy_i     life controller currently owns the RAM
//   ram_addr_o      RAM read address (the row being fetched)
//   scan_busy_o     scanner owns the RAM (address phase in progress)
//   ser_data_o      serial cell data, MSB (bit COLS-1) first
//   ser_clk_o       serial shift clock, data stable on its rising edge
//   latch_o         one-clock pulse, shifted row becomes visible
//   row_sel_o       row currently displayed (updated on latch)
//   next_o          one-clock pulse, request the next generation
//   frame_done_o    one-clock pulse after the last row is latched
//   dbg_state_o     current FSM state encoding, for observation only
//   population_o    (census build only) live cells in the last full frame
//
// RAM handshake: the scanner only claims the RAM from REQ when ctrl_busy_i is
// low, and holds scan_busy_o through REQ-grant and ADDR. Once claimed, a rise
// of ctrl_busy_i is ignored until scan_busy_o drops; the controller waits.
module life_display_scanner #(
    parameter int ROWS           = 15,
    parameter int COLS           = 20,
    parameter int AW             = 4,
    parameter int CLK_DIV        = 4,
    parameter int FRAMES_PER_GEN = 30
) (
    input  logic            clk_50MHz_i,
    input  logic            rst_async_ha_i,
    input  logic            enable_i,
    input  logic [COLS-1:0] row_from_ram_i,
    input  logic            ctrl_busy_i,
    output logic [AW-1:0]   ram_addr_o,
    output logic            scan_busy_o,
    output logic            ser_data_o,
    output logic            ser_clk_o,
    output logic            latch_o,
    output logic [AW-1:0]   row_sel_o,
    output logic            next_o,
    output logic            frame_done_o,
    output logic [2:0]      dbg_state_o
`ifdef LIFE_SCAN_CENSUS_EN
    ,
    output logic [$clog2(ROWS*COLS+1)-1:0] population_o
`endif
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int FW = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_ADDR  = 3'd2,
        S_LOAD  = 3'd3,
        S_SHIFT = 3'd4,
        S_LATCH = 3'd5,
        S_FRAME = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   row_q, row_d;
    logic [AW-1:0]   row_sel_q, row_sel_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic [COLS-1:0] shreg_q, shreg_d;
    logic [DW-1:0]   div_q, div_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic            sclk_q, sclk_d;

    always_ff @(posedge clk_50MHz_i or posedge rst_async_ha_i) begin
        if (rst_async_ha_i) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            row_sel_q <= '0;
            frame_q   <= '0;
            shreg_q   <= '0;
            div_q     <= '0;
            bit_q     <= '0;
            sclk_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            row_sel_q <= row_sel_d;
            frame_q   <= frame_d;
            shreg_q   <= shreg_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            sclk_q    <= sclk_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        row_sel_d    = row_sel_q;
        frame_d      = frame_q;
        shreg_d      = shreg_q;
        div_d        = div_q;
        bit_d        = bit_q;
        sclk_d       = sclk_q;
        scan_busy_o  = 1'b0;
        latch_o      = 1'b0;
        frame_done_o = 1'b0;
        next_o       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable_i) state_d = S_REQ;
            end
            S_REQ: begin
                // The address is already on ram_addr_o; claim the bus only
                // when the controller is not writing.
                if (!ctrl_busy_i) begin
                    scan_busy_o = 1'b1;
                    state_d     = S_ADDR;
                end
            end
            S_ADDR: begin
                scan_busy_o = 1'b1;
                state_d     = S_LOAD;
            end
            S_LOAD: begin
                shreg_d = row_from_ram_i;
                div_d   = '0;
                bit_d   = '0;
                sclk_d  = 1'b0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                // Each bit: CLK_DIV clocks low, then CLK_DIV clocks high.
                // The register advances as ser_clk falls, so ser_data is
                // stable across the whole high phase.
                if (div_q == DW'(CLK_DIV - 1)) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d  = 1'b0;
                        shreg_d = {shreg_q[COLS-2:0], 1'b0};
                        if (bit_q == BW'(COLS - 1)) begin
                            bit_d   = '0;
                            state_d = S_LATCH;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_LATCH: begin
                latch_o   = 1'b1;
                row_sel_d = row_q;
                if (row_q == AW'(ROWS - 1)) begin
                    state_d = S_FRAME;
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = enable_i ? S_REQ : S_IDLE;
                end
            end
            S_FRAME: begin
                frame_done_o = 1'b1;
                row_d        = '0;
                if (frame_q == FW'(FRAMES_PER_GEN - 1)) begin
                    next_o  = 1'b1;
                    frame_d = '0;
                end else begin
                    frame_d = frame_q + 1'b1;
                end
                state_d = enable_i ? S_REQ : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ram_addr_o  = row_q;
    assign row_sel_o   = row_sel_q;
    assign ser_clk_o   = sclk_q;
    assign ser_data_o  = (state_q == S_SHIFT) & shreg_q[COLS-1];
    assign dbg_state_o = state_q;

`ifdef LIFE_SCAN_CENSUS_EN
    localparam int PW = $clog2(ROWS*COLS+1);

    logic [PW-1:0] acc_q, acc_d;
    logic [PW-1:0] pop_q, pop_d;

    function automatic logic [PW-1:0] row_pop(input logic [COLS-1:0] v);
        logic [PW-1:0] n;
        n = '0;
        for (int i = 0; i < COLS; i++) n = n + PW'(v[i]);
        return n;
    endfunction

    always_comb begin
        acc_d = acc_q;
        pop_d = pop_q;
        if (state_q == S_LOAD) begin
            acc_d = acc_q + row_pop(row_from_ram_i);
        end else if (state_q == S_FRAME) begin
            // Publish the finished frame and start the next one from zero.
            pop_d = acc_q;
            acc_d = '0;
        end
    end

    always_ff @(posedge clk_50MHz_i or posedge rst_async_ha_i) begin
        if (rst_async_ha_i) begin
            acc_q <= '0;
            pop_q <= '0;
        end else begin
            acc_q <= acc_d;
            pop_q <= pop_d;
        end
    end

    assign population_o = pop_q;
`endif

endmodule
